dmem_mmio: RTL and testbench

Data-side memory responder for the pipelined RV32 core. It answers the core's M-stage data port (MemWrite, DataAdr, WriteData → ReadData) with a word-addressed data RAM plus a memory-mapped I/O window. The I/O window holds a free-running cycle counter and an output FIFO that stores push into and an external consumer drains through a valid/ready handshake. It sits outside the core, next to the instruction memory, in the top-level wrapper.

---
 rtl/dmem_mmio.sv | 130 +++++++++++++
 tb/tb_dmem_mmio.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// Data-side memory responder: word-addressed data RAM plus an MMIO window
// holding a free-running cycle counter and an output FIFO drained by valid/ready.
module dmem_mmio #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWrite,
    input  logic [WIDTH-1:0] DataAdr,
    input  logic [WIDTH-1:0] WriteData,
    output logic [WIDTH-1:0] ReadData,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] ram [DEPTH];
    logic [WIDTH-1:0] fifoMem [FIFO_DEPTH];

    logic [WIDTH-1:0] cycleCount;
    logic [PW-1:0]    rdPtr;
    logic [PW-1:0]    wrPtr;
    logic [CW-1:0]    fifoCount;
    logic             overflow;

    logic             isMmio;
    logic [AW-1:0]    ramIdx;
    logic [1:0]       mmioSel;
    logic             ramWe;
    logic             cycleWe;
    logic             fifoWr;
    logic             statusWr;
    logic             fifoEmpty;
    logic             fifoFull;
    logic             pop;
    logic             push;
    logic             drop;
    logic [WIDTH-1:0] statusWord;
    logic             unusedBits;

    assign isMmio  = DataAdr[WIDTH-1];
    assign ramIdx  = DataAdr[AW+1:2];
    assign mmioSel = DataAdr[3:2];

    // Address bits outside both decodes are intentionally ignored (aliasing).
    assign unusedBits = ^{DataAdr[WIDTH-2:AW+2], DataAdr[1:0]};

    // Nothing is written on the reset edge, RAM included.
    assign ramWe    = MemWrite & ~isMmio & ~reset;
    assign cycleWe  = MemWrite & isMmio & (mmioSel == 2'd0);
    assign fifoWr   = MemWrite & isMmio & (mmioSel == 2'd1);
    assign statusWr = MemWrite & isMmio & (mmioSel == 2'd2);

    assign fifoEmpty = (fifoCount == '0);
    assign fifoFull  = (fifoCount == CW'(FIFO_DEPTH));
    assign pop       = out_valid & out_ready;
    assign push      = fifoWr & (~fifoFull | pop);
    assign drop      = fifoWr & fifoFull & ~pop;

    assign out_valid = ~fifoEmpty;
    assign out_data  = fifoMem[rdPtr];

    always_comb begin
        statusWord          = '0;
        statusWord[0]       = fifoEmpty;
        statusWord[1]       = fifoFull;
        statusWord[2]       = overflow;
        statusWord[8 +: CW] = fifoCount;
    end

    always_comb begin
        ReadData = '0;
        if (!isMmio) begin
            ReadData = ram[ramIdx];
        end else begin
            case (mmioSel)
                2'd0:    ReadData = cycleCount;
                2'd2:    ReadData = statusWord;
                default: ReadData = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ramWe) begin
            ram[ramIdx] <= WriteData;
        end
    end

    // When full with a same-edge pop, wrPtr equals rdPtr: the slot being
    // overwritten is the head that leaves on this edge.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            fifoMem[wrPtr] <= WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycleCount <= '0;
            rdPtr      <= '0;
            wrPtr      <= '0;
            fifoCount  <= '0;
            overflow   <= 1'b0;
        end else begin
            cycleCount <= cycleWe ? WriteData : cycleCount + WIDTH'(1);
            if (push) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifoCount <= fifoCount + CW'(1);
                2'b01:   fifoCount <= fifoCount - CW'(1);
                default: fifoCount <= fifoCount;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (statusWr && WriteData[2]) begin
                overflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM aliasing, cycle counter, FIFO flow
// control, overflow handling and mid-operation reset.
module tb_dmem_mmio;
    localparam logic [31:0] ADR_CYCLE  = 32'h8000_0000;
    localparam logic [31:0] ADR_FIFO   = 32'h8000_0004;
    localparam logic [31:0] ADR_STATUS = 32'h8000_0008;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;

    dmem_mmio #(.WIDTH(32), .DEPTH(64), .FIFO_DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic readAt(input logic [31:0] adr, output logic [31:0] val);
        DataAdr = adr;
        #1;
        val = ReadData;
    endtask

    task automatic pushWord(input logic [31:0] val);
        MemWrite  = 1'b1;
        DataAdr   = ADR_FIFO;
        WriteData = val;
        tick();
        MemWrite  = 1'b0;
    endtask

    logic [31:0] rd;
    logic [31:0] c1;
    logic [31:0] c2;

    initial begin
        reset     = 1'b1;
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
        out_ready = 1'b0;
        tick();
        tick();

        // Reset state, read while reset still high
        readAt(ADR_CYCLE, rd);  checkVal("reset_cycle", rd, 32'h0);
        readAt(ADR_STATUS, rd); checkVal("reset_status", rd, 32'h0000_0001);
        checkVal("reset_valid", {31'b0, out_valid}, 32'h0);
        reset = 1'b0;

        // RAM write, aliasing and MMIO reads without side effects
        MemWrite = 1'b1; DataAdr = 32'h0000_0010; WriteData = 32'hDEAD_BEEF;
        tick();
        MemWrite = 1'b0;
        readAt(32'h0000_0010, rd); checkVal("ram_read", rd, 32'hDEAD_BEEF);
        readAt(32'h0000_0110, rd); checkVal("ram_alias", rd, 32'hDEAD_BEEF);
        readAt(32'h0000_0013, rd); checkVal("ram_lowbits", rd, 32'hDEAD_BEEF);
        readAt(32'h8000_000C, rd); checkVal("mmio_reserved", rd, 32'h0);
        readAt(ADR_FIFO, rd);      checkVal("mmio_fifo_read", rd, 32'h0);
        readAt(ADR_STATUS, rd);    checkVal("fifo_read_no_pop", rd, 32'h0000_0001);

        // Cycle counter increments and write priority with wrap
        readAt(ADR_CYCLE, c1);
        repeat (4) tick();
        readAt(ADR_CYCLE, c2);
        checkVal("cycle_diff", c2 - c1, 32'd4);
        MemWrite = 1'b1; DataAdr = ADR_CYCLE; WriteData = 32'hFFFF_FFFE;
        tick();
        MemWrite = 1'b0;
        readAt(ADR_CYCLE, rd); checkVal("cycle_load", rd, 32'hFFFF_FFFE);
        tick();
        readAt(ADR_CYCLE, rd); checkVal("cycle_inc", rd, 32'hFFFF_FFFF);
        tick();
        readAt(ADR_CYCLE, rd); checkVal("cycle_wrap", rd, 32'h0);

        // Fill, overflow, drain in order, clear overflow
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) pushWord(32'(i));
        readAt(ADR_STATUS, rd); checkVal("full_status", rd, 32'h0000_0802);
        checkVal("full_head", out_data, 32'd1);
        pushWord(32'd9);
        readAt(ADR_STATUS, rd); checkVal("overflow_status", rd, 32'h0000_0806);
        checkVal("overflow_head", out_data, 32'd1);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checkVal($sformatf("drain_valid_%0d", i), {31'b0, out_valid}, 32'h1);
            checkVal($sformatf("drain_data_%0d", i), out_data, 32'(i));
            tick();
        end
        readAt(ADR_STATUS, rd); checkVal("drained_status", rd, 32'h0000_0005);
        checkVal("drained_valid", {31'b0, out_valid}, 32'h0);
        MemWrite = 1'b1; DataAdr = ADR_STATUS; WriteData = 32'h0000_0004;
        tick();
        MemWrite = 1'b0;
        readAt(ADR_STATUS, rd); checkVal("ovf_cleared", rd, 32'h0000_0001);

        // Push into a full FIFO on the same edge as a pop
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) pushWord(32'h10 + 32'(i));
        out_ready = 1'b1;
        MemWrite = 1'b1; DataAdr = ADR_FIFO; WriteData = 32'hAA;
        #1;
        checkVal("pushpop_head_before", out_data, 32'h10);
        tick();
        MemWrite  = 1'b0;
        out_ready = 1'b0;
        readAt(ADR_STATUS, rd); checkVal("pushpop_status", rd, 32'h0000_0802);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checkVal($sformatf("pushpop_data_%0d", i), out_data,
                     (i == 8) ? 32'hAA : 32'h10 + 32'(i));
            tick();
        end
        readAt(ADR_STATUS, rd); checkVal("pushpop_empty", rd, 32'h0000_0001);

        // No fall-through: push into empty with out_ready held high
        out_ready = 1'b1;
        MemWrite = 1'b1; DataAdr = ADR_FIFO; WriteData = 32'h55;
        #1;
        checkVal("nofall_valid_push", {31'b0, out_valid}, 32'h0);
        tick();
        MemWrite = 1'b0;
        checkVal("nofall_valid_next", {31'b0, out_valid}, 32'h1);
        checkVal("nofall_data_next", out_data, 32'h55);
        tick();
        checkVal("nofall_empty", {31'b0, out_valid}, 32'h0);

        // Reset mid-operation with a concurrent FIFO write
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) pushWord(32'h70 + 32'(i));
        readAt(ADR_STATUS, rd); checkVal("three_queued", rd, 32'h0000_0300);
        reset = 1'b1;
        MemWrite = 1'b1; DataAdr = ADR_FIFO; WriteData = 32'h77;
        tick();
        reset    = 1'b0;
        MemWrite = 1'b0;
        checkVal("rst_valid", {31'b0, out_valid}, 32'h0);
        readAt(ADR_STATUS, rd); checkVal("rst_status", rd, 32'h0000_0001);
        readAt(ADR_CYCLE, rd);  checkVal("rst_cycle", rd, 32'h0);
        tick();
        readAt(ADR_STATUS, rd); checkVal("rst_no_push", rd, 32'h0000_0001);
        readAt(32'h0000_0010, rd); checkVal("ram_kept", rd, 32'hDEAD_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
